ebi_multi_bridge: RTL and testbench

- Next-generation external-bus-interface bridge between the MCU EBI (16-bit async bus) and the FPGA core.
- Assembles CMD_WORDS-word commands into the command FIFO and serves N_CH independent sample FIFOs with per-channel prefetch.
- Runs a prescaled 32-bit global time counter with a coherent high/low read.
- Provides a maskable, sticky interrupt status register.

---
 rtl/ebi_pkg.sv | 36 +++
 rtl/ebi_sample_prefetch.sv | 60 ++++++
 rtl/ebi_multi_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_ebi_multi_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared address map, time commands, IRQ bits and prefetch states for the EBI bridge
package ebi_pkg;

  localparam logic [7:0] ADDR_STATUS       = 8'h00;
  localparam logic [7:0] ADDR_CMD_BASE     = 8'h01;
  localparam logic [7:0] ADDR_TIME_CMD     = 8'h10;
  localparam logic [7:0] ADDR_TIME_L       = 8'h11;
  localparam logic [7:0] ADDR_TIME_H       = 8'h12;
  localparam logic [7:0] ADDR_IRQ_MASK     = 8'h13;
  localparam logic [7:0] ADDR_IRQ_STATUS   = 8'h14;
  localparam logic [7:0] ADDR_READBACK     = 8'h15;
  localparam logic [7:0] ADDR_CMD_COUNT    = 8'h16;
  localparam logic [7:0] ADDR_SAMPLE_DATA  = 8'h20;
  localparam logic [7:0] ADDR_SAMPLE_COUNT = 8'h30;

  localparam logic [15:0] TIME_RUN        = 16'hDEAD;
  localparam logic [15:0] TIME_STOP       = 16'hCAFE;
  localparam logic [15:0] TIME_RESET      = 16'hBEEF;
  localparam logic [15:0] TIME_SOFT_RESET = 16'hD00D;

  localparam int IRQ_CMD_FULL     = 0;
  localparam int IRQ_CMD_OVF      = 1;
  localparam int IRQ_SAMPLE_FULL  = 2;
  localparam int IRQ_SAMPLE_UNDER = 3;
  localparam int IRQ_TIME_WRAP    = 4;
  localparam int IRQ_W            = 5;

  localparam logic [15:0] UNDERFLOW_FILL = 16'hDEAD;

  typedef enum logic [1:0] {
    PF_EMPTY,
    PF_FETCH,
    PF_FULL
  } pf_state_t;

endpackage

// File: rtl/ebi_sample_prefetch.sv
// rtl/ebi_sample_prefetch.sv - one sample channel's read-ahead FSM and capture register
module ebi_sample_prefetch
  import ebi_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              pop,
  output logic              rd_en,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  pf_state_t state;

  // Fetch one word ahead of the host and hold it until the host reads it.
  // In FETCH, rd_en still high means the FIFO registers its word on this edge;
  // the word is captured on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PF_EMPTY;
      rd_en <= 1'b0;
      data  <= DATA_W'(UNDERFLOW_FILL);
      valid <= 1'b0;
    end else begin
      case (state)
        PF_EMPTY: begin
          if (!fifo_empty) begin
            rd_en <= 1'b1;
            state <= PF_FETCH;
          end
        end
        PF_FETCH: begin
          if (rd_en) begin
            rd_en <= 1'b0;
          end else begin
            data  <= fifo_data;
            valid <= 1'b1;
            state <= PF_FULL;
          end
        end
        PF_FULL: begin
          if (pop) begin
            valid <= 1'b0;
            state <= PF_EMPTY;
          end
        end
        default: begin
          state <= PF_EMPTY;
          rd_en <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ebi_multi_bridge.sv
// rtl/ebi_multi_bridge.sv - EBI bridge: command assembly, sample prefetch, time counter, IRQ
module ebi_multi_bridge
  import ebi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CMD_WORDS = 5,
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  input  logic [7:0]                  addr,
  input  logic                        rd,
  input  logic                        wr,
  input  logic                        cs,
  output logic                        softy_reset,
  output logic [DATA_W*CMD_WORDS-1:0] cmd_fifo_data_in,
  output logic                        cmd_fifo_wr_en,
  input  logic                        cmd_fifo_full,
  input  logic                        cmd_fifo_almost_full,
  input  logic                        cmd_fifo_empty,
  input  logic [CNT_W-1:0]            cmd_fifo_data_count,
  input  logic [DATA_W*N_CH-1:0]      sample_fifo_data_out,
  output logic [N_CH-1:0]             sample_fifo_rd_en,
  input  logic [N_CH-1:0]             sample_fifo_empty,
  input  logic [N_CH-1:0]             sample_fifo_full,
  input  logic [CNT_W*N_CH-1:0]       sample_fifo_data_count,
  output logic [31:0]                 global_clock,
  output logic                        global_clock_running,
  output logic                        irq
);

  logic                         rd_s, wr_s;
  logic [2:0]                   rd_sync, wr_sync;
  logic                         rd_rise, wr_rise, rd_done, wr_done;
  logic [7:0]                   addr_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [DATA_W-1:0]            cmd_words [CMD_WORDS];
  logic [DATA_W-1:0]            readback, irq_mask, rd_mux;
  logic [IRQ_W-1:0]             irq_status, irq_set, irq_w1c;
  logic                         cmd_full_q;
  logic [N_CH-1:0]              sample_full_q;
  logic [31:0]                  time_cnt, presc;
  logic [15:0]                  time_h_snap;
  logic                         time_cmd_hit, time_clear, time_tick, time_wrap, commit;
  logic [N_CH-1:0]              pf_valid, pf_pop, pf_under;
  logic [N_CH-1:0][DATA_W-1:0]  pf_data;

  assign rd_s    = cs & rd;
  assign wr_s    = cs & wr;
  assign rd_rise = rd_sync[1] & ~rd_sync[2];
  assign wr_rise = wr_sync[1] & ~wr_sync[2];
  assign rd_done = rd_sync[2] & ~rd_sync[1];
  assign wr_done = wr_sync[2] & ~wr_sync[1];

  // Two-flop synchronisers for the async strobes plus one stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sync <= '0;
      wr_sync <= '0;
    end else begin
      rd_sync <= {rd_sync[1:0], rd_s};
      wr_sync <= {wr_sync[1:0], wr_s};
    end
  end

  // Hold address and write data from the synchronised strobe start until its completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (rd_rise || wr_rise) addr_q <= addr;
      if (wr_rise) wdata_q <= data_in;
    end
  end

  // Register-file writes, applied when a write strobe completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CMD_WORDS; i++) cmd_words[i] <= '0;
      readback <= '0;
      irq_mask <= '0;
    end else if (wr_done) begin
      readback <= wdata_q;
      if (addr_q == ADDR_IRQ_MASK) irq_mask <= wdata_q;
      for (int i = 0; i < CMD_WORDS; i++)
        if (addr_q == ADDR_CMD_BASE + 8'(i)) cmd_words[i] <= wdata_q;
    end
  end

  // Word 1 sits in the most significant slot of the command bus
  always_comb begin
    cmd_fifo_data_in = '0;
    for (int i = 0; i < CMD_WORDS; i++)
      cmd_fifo_data_in[(CMD_WORDS-1-i)*DATA_W +: DATA_W] = cmd_words[i];
  end

  assign commit = wr_done && (addr_q == ADDR_CMD_BASE + 8'(CMD_WORDS - 1));

  // Push the assembled command once the last word lands, unless the FIFO is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_fifo_wr_en <= 1'b0;
    else      cmd_fifo_wr_en <= commit & ~cmd_fifo_full;
  end

  assign time_cmd_hit = wr_done && (addr_q == ADDR_TIME_CMD);
  assign time_clear   = time_cmd_hit && (wdata_q == DATA_W'(TIME_RESET));
  assign time_tick    = global_clock_running && (presc == 32'(PRESCALE - 1));
  assign time_wrap    = time_tick && (time_cnt == 32'hFFFF_FFFF) && !time_clear;
  assign global_clock = time_cnt;

  // Prescaled global time counter and TIME_CMD handling; clear beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_cnt             <= '0;
      presc                <= '0;
      global_clock_running <= 1'b0;
      softy_reset          <= 1'b0;
    end else begin
      softy_reset <= time_cmd_hit && (wdata_q == DATA_W'(TIME_SOFT_RESET));
      if (time_clear) begin
        time_cnt             <= '0;
        presc                <= '0;
        global_clock_running <= 1'b0;
      end else begin
        if (time_cmd_hit && (wdata_q == DATA_W'(TIME_RUN)))       global_clock_running <= 1'b1;
        else if (time_cmd_hit && (wdata_q == DATA_W'(TIME_STOP))) global_clock_running <= 1'b0;
        if (time_tick) begin
          presc    <= '0;
          time_cnt <= time_cnt + 32'd1;
        end else if (global_clock_running) begin
          presc <= presc + 32'd1;
        end
      end
    end
  end

  // Per-channel consume (full) or underflow (not full) at the end of a sample read
  always_comb begin
    pf_pop   = '0;
    pf_under = '0;
    for (int c = 0; c < N_CH; c++) begin
      pf_pop[c]   = rd_done && (addr_q == ADDR_SAMPLE_DATA + 8'(c)) && pf_valid[c];
      pf_under[c] = rd_done && (addr_q == ADDR_SAMPLE_DATA + 8'(c)) && !pf_valid[c];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ebi_sample_prefetch #(.DATA_W(DATA_W)) u_prefetch (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (sample_fifo_empty[c]),
      .fifo_data  (sample_fifo_data_out[c*DATA_W +: DATA_W]),
      .pop        (pf_pop[c]),
      .rd_en      (sample_fifo_rd_en[c]),
      .data       (pf_data[c]),
      .valid      (pf_valid[c])
    );
  end

  // Sticky interrupt sources
  always_comb begin
    irq_set                   = '0;
    irq_set[IRQ_CMD_FULL]     = cmd_fifo_full & ~cmd_full_q;
    irq_set[IRQ_CMD_OVF]      = commit & cmd_fifo_full;
    irq_set[IRQ_SAMPLE_FULL]  = |(sample_fifo_full & ~sample_full_q);
    irq_set[IRQ_SAMPLE_UNDER] = |pf_under;
    irq_set[IRQ_TIME_WRAP]    = time_wrap;
  end

  assign irq_w1c = (wr_done && (addr_q == ADDR_IRQ_STATUS)) ? wdata_q[IRQ_W-1:0] : '0;

  // Status update with set winning over clear; irq follows status one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_full_q    <= 1'b0;
      sample_full_q <= '0;
      irq_status    <= '0;
      irq           <= 1'b0;
    end else begin
      cmd_full_q    <= cmd_fifo_full;
      sample_full_q <= sample_fifo_full;
      irq_status    <= (irq_status & ~irq_w1c) | irq_set;
      irq           <= |(irq_status & irq_mask[IRQ_W-1:0]);
    end
  end

  // Read source selection from the live EBI address
  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_STATUS)
      rd_mux = DATA_W'({cmd_fifo_almost_full, cmd_fifo_full, cmd_fifo_empty,
                        |sample_fifo_full, |sample_fifo_empty, irq, 10'h0});
    if (addr == ADDR_TIME_L)     rd_mux = DATA_W'(time_cnt[15:0]);
    if (addr == ADDR_TIME_H)     rd_mux = DATA_W'(time_h_snap);
    if (addr == ADDR_IRQ_MASK)   rd_mux = irq_mask;
    if (addr == ADDR_IRQ_STATUS) rd_mux = DATA_W'(irq_status);
    if (addr == ADDR_READBACK)   rd_mux = readback;
    if (addr == ADDR_CMD_COUNT)  rd_mux = DATA_W'(cmd_fifo_data_count);
    for (int i = 0; i < CMD_WORDS; i++)
      if (addr == ADDR_CMD_BASE + 8'(i)) rd_mux = cmd_words[i];
    for (int c = 0; c < N_CH; c++) begin
      if (addr == ADDR_SAMPLE_DATA + 8'(c))
        rd_mux = pf_valid[c] ? pf_data[c] : DATA_W'(UNDERFLOW_FILL);
      if (addr == ADDR_SAMPLE_COUNT + 8'(c))
        rd_mux = DATA_W'(sample_fifo_data_count[c*CNT_W +: CNT_W]);
    end
  end

  // Refresh read data every cycle of a read; TIME_H is snapshotted alongside TIME_L
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      time_h_snap <= '0;
    end else if (rd_s) begin
      data_out <= rd_mux;
      if (addr == ADDR_TIME_L) time_h_snap <= time_cnt[31:16];
    end
  end

endmodule

// File: tb/tb_ebi_multi_bridge.sv
// tb/tb_ebi_multi_bridge.sv - randomized self-checking bench for ebi_multi_bridge
module tb_ebi_multi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [7:0]  addr = '0;
  logic        rd = 1'b0, wr = 1'b0, cs = 1'b0;
  logic        softy_reset;
  logic [79:0] cmd_fifo_data_in;
  logic        cmd_fifo_wr_en;
  logic        cmd_fifo_full = 1'b0, cmd_fifo_almost_full = 1'b0, cmd_fifo_empty = 1'b1;
  logic [15:0] cmd_fifo_data_count = '0;
  logic [63:0] sample_fifo_data_out;
  logic [3:0]  sample_fifo_rd_en;
  logic [3:0]  sample_fifo_empty;
  logic [3:0]  sample_fifo_full = '0;
  logic [63:0] sample_fifo_data_count = '0;
  logic [31:0] global_clock;
  logic        global_clock_running;
  logic        irq;

  ebi_multi_bridge #(.DATA_W(16), .CMD_WORDS(5), .N_CH(4), .CNT_W(16), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .addr(addr),
    .rd(rd), .wr(wr), .cs(cs), .softy_reset(softy_reset),
    .cmd_fifo_data_in(cmd_fifo_data_in), .cmd_fifo_wr_en(cmd_fifo_wr_en),
    .cmd_fifo_full(cmd_fifo_full), .cmd_fifo_almost_full(cmd_fifo_almost_full),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_data_count(cmd_fifo_data_count),
    .sample_fifo_data_out(sample_fifo_data_out), .sample_fifo_rd_en(sample_fifo_rd_en),
    .sample_fifo_empty(sample_fifo_empty), .sample_fifo_full(sample_fifo_full),
    .sample_fifo_data_count(sample_fifo_data_count), .global_clock(global_clock),
    .global_clock_running(global_clock_running), .irq(irq)
  );

  always #5 clk = ~clk;

  // channel 2 sample FIFO with one-cycle read latency; other channels stay empty
  logic [15:0] ch2_mem [16];
  int          ch2_wp = 0;
  int          ch2_rp = 0;
  logic [15:0] ch2_dout = '0;
  always @(posedge clk)
    if (sample_fifo_rd_en[2] && ch2_rp != ch2_wp) begin
      ch2_dout <= ch2_mem[ch2_rp % 16];
      ch2_rp   <= ch2_rp + 1;
    end
  assign sample_fifo_empty    = {1'b1, (ch2_wp == ch2_rp), 1'b1, 1'b1};
  assign sample_fifo_data_out = {16'h0, ch2_dout, 32'h0};

  // output event counters
  int          wr_en_cnt = 0;
  int          soft_cnt = 0;
  int          rd_en_cnt [4] = '{default: 0};
  logic [79:0] last_cmd = '0;
  always @(posedge clk) begin
    if (cmd_fifo_wr_en) begin
      wr_en_cnt = wr_en_cnt + 1;
      last_cmd  = cmd_fifo_data_in;
    end
    if (softy_reset) soft_cnt = soft_cnt + 1;
    for (int c = 0; c < 4; c++) if (sample_fifo_rd_en[c]) rd_en_cnt[c] = rd_en_cnt[c] + 1;
  end

  // reference model of the register file
  logic [15:0] m_cmd [5];
  logic [15:0] m_readback, m_mask;
  logic [4:0]  m_irq;
  logic [15:0] exp_samples [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_cmd[i] = '0;
    m_readback = '0;
    m_mask     = '0;
    m_irq      = '0;
  endtask

  task automatic ebi_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; data_in = d; cs = 1'b1; wr = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    repeat (8) @(negedge clk);
    m_readback = d;
    for (int i = 0; i < 5; i++) if (a == 8'(i + 1)) m_cmd[i] = d;
    if (a == 8'h13) m_mask = d;
    if (a == 8'h14) m_irq = m_irq & ~d[4:0];
  endtask

  task automatic ebi_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; cs = 1'b1; rd = 1'b1;
    repeat (4) @(negedge clk);
    d = data_out;
    cs = 1'b0; rd = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_ch2(input logic [15:0] v);
    ch2_mem[ch2_wp % 16] = v;
    ch2_wp = ch2_wp + 1;
    exp_samples.push_back(v);
  endtask

  logic [15:0] r, r2, w;
  logic [31:0] t0, t1;
  int          n_wr, n_rd, k;
  bit          seen;

  initial begin
    model_reset();
    cmd_fifo_data_count    = 16'($urandom);
    sample_fifo_data_count = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_cmd_bus", cmd_fifo_data_in, 0);
    check_eq("rst_outputs", {cmd_fifo_wr_en, sample_fifo_rd_en, softy_reset, irq, global_clock_running}, 0);
    check_eq("rst_time", global_clock, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    ebi_read(8'h00, r);
    check_eq("status", r, {cmd_fifo_almost_full, cmd_fifo_full, cmd_fifo_empty,
                           |sample_fifo_full, |sample_fifo_empty, 1'b0, 10'h0});

    // fixed command
    for (int i = 1; i <= 5; i++) begin
      ebi_write(8'(i), 16'(i * 32'h1111));
      if (i == 4) check_eq("no_early_commit", wr_en_cnt, 0);
    end
    check_eq("commit_pulses", wr_en_cnt, 1);
    check_eq("commit_data", last_cmd, 80'h1111_2222_3333_4444_5555);
    ebi_read(8'h03, r);
    check_eq("word_retained", r, 16'h3333);

    // random commands
    for (int it = 0; it < 4; it++) begin
      for (int i = 1; i <= 5; i++) ebi_write(8'(i), 16'($urandom));
      check_eq("rand_commit_pulses", wr_en_cnt, 2 + it);
      check_eq("rand_commit_data", last_cmd, {m_cmd[0], m_cmd[1], m_cmd[2], m_cmd[3], m_cmd[4]});
      k = $urandom_range(1, 5);
      ebi_read(8'(k), r);
      check_eq("rand_word_read", r, m_cmd[k - 1]);
    end

    // unmapped access and counts
    w = 16'($urandom);
    ebi_write(8'h40, w);
    ebi_read(8'h40, r);
    check_eq("unmapped_read", r, 0);
    ebi_read(8'h15, r);
    check_eq("readback", r, m_readback);
    ebi_read(8'h16, r);
    check_eq("cmd_count", r, cmd_fifo_data_count);
    ebi_read(8'h32, r);
    check_eq("sample_count2", r, sample_fifo_data_count[47:32]);

    // command overflow
    n_wr = wr_en_cnt;
    cmd_fifo_full = 1'b1;
    m_irq[0] = 1'b1;
    repeat (3) @(negedge clk);
    ebi_read(8'h14, r);
    check_eq("irq_full_rise", r, m_irq);
    ebi_write(8'h14, 16'h001F);
    ebi_write(8'h13, 16'h0002);
    ebi_read(8'h13, r);
    check_eq("irq_mask", r, m_mask);
    for (int i = 1; i <= 5; i++) ebi_write(8'(i), 16'($urandom));
    m_irq[1] = 1'b1;
    check_eq("ovf_no_wr_en", wr_en_cnt, n_wr);
    ebi_read(8'h14, r);
    check_eq("ovf_status", r, m_irq);
    check_eq("ovf_irq", irq, |(m_irq & m_mask[4:0]));
    ebi_write(8'h14, 16'h0002);
    check_eq("ovf_irq_cleared", irq, |(m_irq & m_mask[4:0]));
    cmd_fifo_full = 1'b0;

    // sample channel 2
    push_ch2(16'hA001);
    push_ch2(16'hA002);
    for (int i = 0; i < 3; i++) push_ch2(16'($urandom));
    repeat (6) @(negedge clk);
    while (exp_samples.size() > 0) begin
      ebi_read(8'h22, r);
      check_eq("sample_ch2", r, exp_samples.pop_front());
    end
    ebi_read(8'h22, r);
    check_eq("sample_underflow_data", r, 16'hDEAD);
    m_irq[3] = 1'b1;
    ebi_read(8'h14, r);
    check_eq("sample_underflow_irq", r, m_irq);
    check_eq("ch2_reads", rd_en_cnt[2], 5);
    check_eq("ch0_untouched", rd_en_cnt[0], 0);
    ebi_read(8'h20, r);
    check_eq("ch0_underflow_data", r, 16'hDEAD);
    ebi_write(8'h14, 16'h001F);

    // time counter
    ebi_write(8'h10, 16'hDEAD);
    check_eq("time_running", global_clock_running, 1);
    repeat (40) @(negedge clk);
    ebi_read(8'h11, r);
    check_eq("time_l_window", (r >= 16'd10 && r <= 16'd13), 1);
    t0 = global_clock;
    repeat (20) @(negedge clk);
    t1 = global_clock;
    check_eq("prescale_rate", t1 - t0, 5);
    ebi_write(8'h10, 16'hCAFE);
    check_eq("time_stopped", global_clock_running, 0);
    t0 = global_clock;
    repeat (20) @(negedge clk);
    check_eq("time_hold", global_clock, t0);
    ebi_read(8'h11, r);
    check_eq("time_hold_read", r, t0[15:0]);
    ebi_write(8'h10, 16'h1234);
    check_eq("time_ignored_cmd", {global_clock_running, global_clock}, {1'b0, t0});
    ebi_write(8'h10, 16'hBEEF);
    check_eq("time_clear", {global_clock_running, global_clock}, 33'h0);

    // wrap
    ebi_write(8'h10, 16'hDEAD);
    @(negedge clk);
    force dut.time_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.time_cnt;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (global_clock == 32'h0) seen = 1'b1;
    end
    check_eq("wrap_to_zero", seen, 1);
    m_irq[4] = 1'b1;
    ebi_read(8'h14, r);
    check_eq("wrap_irq", r, m_irq);

    // coherent high/low across a carry of the low word
    @(negedge clk);
    force dut.time_cnt = 32'h0000_FFFE;
    #1;
    release dut.time_cnt;
    ebi_read(8'h11, r);
    ebi_read(8'h12, r2);
    check_eq("coherent_pair", r2, (r >= 16'h8000) ? 16'h0000 : 16'h0001);
    check_eq("carry_happened", global_clock[31:16], 16'h0001);

    // soft reset pulse
    n_wr = soft_cnt;
    ebi_write(8'h10, 16'hD00D);
    check_eq("soft_reset_pulse", soft_cnt - n_wr, 1);

    // reset in the middle of a read of channel 0
    n_rd = rd_en_cnt[0] + rd_en_cnt[1] + rd_en_cnt[2] + rd_en_cnt[3];
    @(negedge clk);
    addr = 8'h20; cs = 1'b1; rd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_outputs", {data_out, cmd_fifo_wr_en, sample_fifo_rd_en, softy_reset, irq,
                                 global_clock_running, global_clock}, 0);
    repeat (2) @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("no_rd_en_after_rst", rd_en_cnt[0] + rd_en_cnt[1] + rd_en_cnt[2] + rd_en_cnt[3], n_rd);
    ebi_read(8'h14, r);
    check_eq("rst_irq_status", r, m_irq);
    ebi_read(8'h13, r);
    check_eq("rst_irq_mask", r, m_mask);

    // reset in the middle of the committing write
    for (int i = 1; i <= 4; i++) ebi_write(8'(i), 16'($urandom));
    n_wr = wr_en_cnt;
    @(negedge clk);
    addr = 8'h05; data_in = 16'($urandom); cs = 1'b1; wr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("no_wr_en_after_rst", wr_en_cnt, n_wr);
    ebi_read(8'h01, r);
    check_eq("rst_cmd_word", r, m_cmd[0]);
    ebi_read(8'h15, r);
    check_eq("rst_readback", r, m_readback);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
